accelerator_matrix_stream_controller: RTL
=========================================

ACCELERATOR_MATRIX_STREAM_CONTROLLER -- requirements
Module: accelerator_matrix_stream_controller

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64: data and size word width.
REQ-002 SHALL have parameter CONTROL_SIZE, default 4: control word width; MODE uses bits [1:0].
REQ-003 SHALL have parameter CHANNELS, default 4: number of independent matrix buffers.
REQ-004 SHALL have parameters MAX_I = 8 and MAX_J = 8: maximum rows and columns per channel.
REQ-005 SHALL have CLK, input, 1: single clock, rising edge.
REQ-006 SHALL have RST, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have START, input, 1: operation request, sampled only in IDLE.
REQ-008 SHALL have READY, output, 1: one-cycle completion pulse.
REQ-009 SHALL have ERROR, output, 1: valid only while READY=1.
REQ-010 SHALL have MODE, input, CONTROL_SIZE: 0 = load, 1 = accumulate, 2 = read, 3+ = illegal.
REQ-011 SHALL have CHANNEL, input, DATA_SIZE: target buffer index.
REQ-012 SHALL have SIZE_I_IN and SIZE_J_IN, inputs, DATA_SIZE each: row and column counts.
REQ-013 SHALL have DATA_IN, input, DATA_SIZE, plus DATA_IN_I_ENABLE and DATA_IN_J_ENABLE, inputs, 1 each: element valid and row-start markers.
REQ-014 SHALL have DATA_OUT_I_ENABLE and DATA_OUT_J_ENABLE, outputs, 1 each: element request/valid and row-start markers.
REQ-015 SHALL have DATA_OUT, output, DATA_SIZE: read data.

Function
REQ-016 SHALL latch MODE, CHANNEL and both sizes at START in IDLE, and SHALL ignore START in any other state.
REQ-017 SHALL treat the operation as illegal if any size is 0, SIZE_I_IN > MAX_I, SIZE_J_IN > MAX_J, CHANNEL >= CHANNELS or MODE > 2; an illegal operation SHALL go directly to DONE with ERROR=1, make no transfers and leave memory unchanged.
REQ-018 SHALL implement the states IDLE, REQUEST, WAIT, STREAM and DONE.
REQ-019 SHALL traverse elements row-major: j runs 0..SIZE_J-1 inside i, which runs 0..SIZE_I-1.
REQ-020 In load and accumulate mode, REQUEST SHALL pulse DATA_OUT_J_ENABLE for one cycle, with DATA_OUT_I_ENABLE also high when j==0, then enter WAIT.
REQ-021 WAIT SHALL hold until DATA_IN_J_ENABLE=1; DATA_IN SHALL be sampled only in WAIT, starting the cycle after the request pulse.
REQ-022 On acceptance, the controller SHALL write DATA_IN (load) or the stored value + DATA_IN modulo 2^DATA_SIZE (accumulate) to mem[CHANNEL][i][j].
REQ-023 After each accepted element, the controller SHALL advance the indices and return to REQUEST; after the last element it SHALL go to DONE.
REQ-024 If DATA_IN_I_ENABLE=0 when the accepted element has j==0, a sticky row-sync error SHALL be set; the write SHALL still occur and ERROR=1 SHALL be reported at READY.
REQ-025 In read mode, STREAM SHALL emit one element per cycle with no backpressure: DATA_OUT, DATA_OUT_J_ENABLE=1, and DATA_OUT_I_ENABLE=1 when j==0.
REQ-026 In read mode, all outputs SHALL be registered together.
REQ-027 For read mode with START sampled in cycle t, the first element SHALL appear in cycle t+2, consecutive elements in consecutive cycles, and READY in cycle t+2+I*J.
REQ-028 DONE SHALL last exactly one cycle with READY=1 before returning to IDLE; a new START SHALL be accepted in the following cycle.
REQ-029 DATA_OUT SHALL hold its last value while idle; the enable outputs SHALL be 0 outside their defined pulses.
REQ-030 Channels SHALL be fully independent; an operation SHALL NOT modify any channel other than CHANNEL.

Reset
REQ-031 While RST=1, asynchronously: FSM SHALL be IDLE, indices 0, sticky error cleared, and READY, ERROR, all enables and DATA_OUT 0.
REQ-032 Reset mid-operation SHALL abort without READY; memory contents SHALL NOT be reset, and elements already written SHALL remain.

Verification
REQ-033 Load ch1, 2x3, values 1..6, then read -> DATA_OUT 1..6 on consecutive cycles, I_ENABLE on elements 1 and 4, READY at t+8, ERROR=0.
REQ-034 Load ch0, 2x2, all 5, then accumulate 3 -> read 8,8,8,8; a stored 0xFFFF_FFFF_FFFF_FFFF accumulated with 2 -> reads 1.
REQ-035 SIZE_I_IN=0, SIZE_J_IN=9, CHANNEL=4 or MODE=3 (each separately) -> READY=1 and ERROR=1 two cycles after START, no enable pulses, memory unchanged.
REQ-036 Load ch2 with 10.. and ch3 with 20.., then read both -> no cross-channel corruption.
REQ-037 Assert RST after 2 of 4 load elements -> all outputs 0, no READY; next START completes normally; the 2 written elements are retained.
REQ-038 START pulsed during STREAM is ignored; a load where DATA_IN_I_ENABLE is missing at row start -> data is written and READY comes with ERROR=1.

Source files
------------

// File: rtl/accelerator_matrix_stream_controller.sv
// Matrix stream controller: per-channel MAX_I x MAX_J word buffers.
// Three operations are supported: load a matrix through a request/acknowledge
// handshake, accumulate onto a stored matrix, or stream it back out one
// element per cycle.
//
// Ports
//   CLK, RST               clock (rising edge), asynchronous active-high reset
//   START                  operation request, sampled only while idle
//   MODE                   0 load, 1 accumulate, 2 read, others illegal
//   CHANNEL                target buffer index
//   SIZE_I_IN, SIZE_J_IN   row / column counts of the operation
//   DATA_IN                element data for load/accumulate
//   DATA_IN_I_ENABLE       row-start marker that accompanies DATA_IN
//   DATA_IN_J_ENABLE       element valid that accompanies DATA_IN
//   DATA_OUT_J_ENABLE      element request (load/acc) or element valid (read)
//   DATA_OUT_I_ENABLE      row-start marker for DATA_OUT_J_ENABLE
//   DATA_OUT               read data, holds its last value otherwise
//   READY, ERROR           one-cycle completion pulse with its status
module accelerator_matrix_stream_controller #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned MAX_I        = 8,
  parameter int unsigned MAX_J        = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    ERROR,
  input  logic [CONTROL_SIZE-1:0] MODE,
  input  logic [DATA_SIZE-1:0]    CHANNEL,
  input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  input  logic                    DATA_IN_I_ENABLE,
  input  logic                    DATA_IN_J_ENABLE,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IW  = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int unsigned JW  = (MAX_J > 1) ? $clog2(MAX_J) : 1;
  localparam int unsigned SIW = $clog2(MAX_I + 1);
  localparam int unsigned SJW = $clog2(MAX_J + 1);

  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_ACC  = 2'd1;
  localparam logic [1:0] MODE_READ = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [SIW-1:0]         size_i_q, size_i_d;
  logic [SJW-1:0]         size_j_q, size_j_d;
  logic [IW-1:0]          i_q, i_d;
  logic [JW-1:0]          j_q, j_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic                   out_i_q, out_i_d;
  logic                   out_j_q, out_j_d;
  logic [DATA_SIZE-1:0]   data_out_q, data_out_d;

  logic [DATA_SIZE-1:0]   mem_q [CHANNELS][MAX_I][MAX_J];

  logic                   illegal_c;
  logic                   last_i_c;
  logic                   last_j_c;
  logic                   last_elem_c;
  logic [IW-1:0]          i_nxt_c;
  logic [JW-1:0]          j_nxt_c;
  logic [DATA_SIZE-1:0]   rd_word_c;
  logic [DATA_SIZE-1:0]   mem_wdata_c;
  logic                   mem_we_c;

  // Request legality, checked on the raw inputs while idle
  assign illegal_c = (SIZE_I_IN == '0) || (SIZE_I_IN > DATA_SIZE'(MAX_I)) ||
                     (SIZE_J_IN == '0) || (SIZE_J_IN > DATA_SIZE'(MAX_J)) ||
                     (CHANNEL >= DATA_SIZE'(CHANNELS)) ||
                     (MODE > CONTROL_SIZE'(2));

  // Row-major index walk: j wraps inside i
  assign last_j_c    = (SJW'(j_q) + SJW'(1)) == size_j_q;
  assign last_i_c    = (SIW'(i_q) + SIW'(1)) == size_i_q;
  assign last_elem_c = last_i_c && last_j_c;
  assign j_nxt_c     = last_j_c ? '0 : j_q + JW'(1);
  assign i_nxt_c     = last_j_c ? i_q + IW'(1) : i_q;

  // Element at the current index; also the accumulate operand
  assign rd_word_c   = mem_q[ch_q][i_q][j_q];
  assign mem_wdata_c = (mode_q == MODE_ACC) ? rd_word_c + DATA_IN : DATA_IN;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    size_i_d   = size_i_q;
    size_j_d   = size_j_q;
    i_d        = i_q;
    j_d        = j_q;
    err_d      = err_q;
    mem_we_c   = 1'b0;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    out_i_d    = 1'b0;
    out_j_d    = 1'b0;
    data_out_d = data_out_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d   = MODE[1:0];
          ch_d     = CW'(CHANNEL);
          size_i_d = SIW'(SIZE_I_IN);
          size_j_d = SJW'(SIZE_J_IN);
          i_d      = '0;
          j_d      = '0;
          err_d    = illegal_c;
          if (illegal_c) begin
            state_d = ST_DONE;
          end else if (MODE[1:0] == MODE_READ) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_REQUEST;
          end
        end
      end
      ST_REQUEST: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (DATA_IN_J_ENABLE) begin
          mem_we_c = 1'b1;
          // Row start without its marker: keep the data, flag at completion
          if ((j_q == '0) && !DATA_IN_I_ENABLE) begin
            err_d = 1'b1;
          end
          i_d     = i_nxt_c;
          j_d     = j_nxt_c;
          state_d = last_elem_c ? ST_DONE : ST_REQUEST;
        end
      end
      ST_STREAM: begin
        i_d     = i_nxt_c;
        j_d     = j_nxt_c;
        state_d = last_elem_c ? ST_DONE : ST_STREAM;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request pulse lines up with the REQUEST state; stream data trails the
    // STREAM state by one cycle, and READY trails DONE by one cycle.
    ready_d = (state_q == ST_DONE);
    error_d = (state_q == ST_DONE) && err_q;
    out_j_d = (state_d == ST_REQUEST) || (state_q == ST_STREAM);
    out_i_d = ((state_d == ST_REQUEST) && (j_d == '0)) ||
              ((state_q == ST_STREAM) && (j_q == '0));
    if (state_q == ST_STREAM) begin
      data_out_d = rd_word_c;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation context, indices and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q     <= MODE_LOAD;
      ch_q       <= '0;
      size_i_q   <= '0;
      size_j_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      out_i_q    <= 1'b0;
      out_j_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      size_i_q   <= size_i_d;
      size_j_q   <= size_j_d;
      i_q        <= i_d;
      j_q        <= j_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      out_i_q    <= out_i_d;
      out_j_q    <= out_j_d;
      data_out_q <= data_out_d;
    end
  end

  // Buffer storage survives reset so partially written matrices remain
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem_q[ch_q][i_q][j_q] <= mem_wdata_c;
    end
  end

  assign READY             = ready_q;
  assign ERROR             = error_q;
  assign DATA_OUT_I_ENABLE = out_i_q;
  assign DATA_OUT_J_ENABLE = out_j_q;
  assign DATA_OUT          = data_out_q;

endmodule
